alu_pipe_fwd: RTL and testbench
===============================

# alu_pipe_fwd

Parametrised single-clock successor to the team's four-stage register-read / ALU / register-writeback / memory-write pipeline. Adds a valid/ready input handshake, a global hold, and full operand forwarding, so back-to-back dependent operations need no software-inserted bubbles. It also widens the ALU function set and brings data and address widths out as parameters. Sits between the instruction-issue logic and the local data memory; exposes debug read ports for the register bank and memory.

## Interface

- DATA_W, 16, operand/result width (≥ 8)
- REG_AW, 4, register address width; bank has 2**REG_AW entries
- MEM_AW, 8, memory address width; memory has 2**MEM_AW entries
- clk  in  1  single pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  = !hold; operation accepted on an edge where in_valid && in_ready
- hold  in  1  freezes every stage; no register-bank or memory write occurs
- rs1, rs2, rd  in  REG_AW  source and destination register addresses
- func  in  4  ALU function
- addr  in  MEM_AW  memory write address
- z_out  out  DATA_W  stage-3 result
- z_valid  out  1  z_out holds a valid result
- z_zero  out  1  z_out == 0 (qualified by z_valid)
- z_carry  out  1  carry-out for add, borrow for sub, else 0
- rf_dbg_addr  in  REG_AW / rf_dbg_data  out  DATA_W  combinational register-bank read
- mem_dbg_addr  in  MEM_AW / mem_dbg_data  out  DATA_W  combinational memory read

## Operation

- Stage S1 (register read, on accept edge): latch operands A and B, plus rd, func, addr, and v1 = 1. A bubble (in_valid=0, hold=0) latches v1 = 0.
- Operand source, highest priority first:
  - ALU output of the valid S1→S2 entry whose rd matches
  - S2→S3 result whose rd matches and whose valid bit is set
  - register bank
- Applied independently to rs1 and rs2.
- Stage S2 (ALU) func codes:
  - 1 A+B; 2 A−B; 3 A&B; 4 A|B; 5 A^B; 6 ~B; 7 ~A
  - 8 A<<B[log2(DATA_W)-1:0]; 9 logical A>>same; 10 pass A
  - 11 (A<B unsigned) ? 1 : 0
  - all others → 0
- Result is DATA_W bits, truncated. Carry/borrow is the bit DATA_W of the DATA_W+1-bit sum/difference.
- Stage S3 (writeback): on advancing edge, if valid, write bank[rd] and latch result, flags and addr into the S3→S4 registers. The S3 valid bit drives z_valid.
- Stage S4 (memory): on next advancing edge, if valid, mem[addr] = result.
- Invalid entries never write the bank or memory.
- hold=1: every stage register and valid bit keeps its value, no writes occur, and forwarding continues from the frozen contents.

## Timing

- Accept at edge N. ALU result is registered at N+1. Bank write, z_out and z_valid occur at N+2. Memory write occurs at N+3. Each hold cycle adds one cycle.
- Throughput: one operation per cycle when hold=0.
- Same-edge bank write and S1 read of the same register: forwarding from S2→S3 supplies the new value, so no stale read.
- rd equal in S2 and S3 entries: the S2 (younger) value wins.
- Reset (asserted at any time, including mid-stream):
  - all valid bits 0 and all stage registers 0
  - z_out, z_zero and z_carry read 0; z_valid reads 0
  - register bank cleared to 0
  - memory contents retained, with no write on the reset edge
  - in-flight operations are discarded
- After rst_n deasserts, the first acceptance is possible on the first clk edge.

## Test plan

- Reset values:
  - Stimulus: assert rst_n=0 mid-stream with 3 operations in flight.
  - Response: z_valid=0 and z_out=0 immediately; rf_dbg_data=0 for all registers; no memory location changes afterwards.
- Back-to-back RAW chain:
  - Setup: r1=5, r2=3.
  - Stimulus: issue add r3=r1+r2, then sub r4=r3−r1, then xor r5=r4^r3, on consecutive cycles.
  - Response: z_out sequence is 8, 3, 11; bank holds r3=8, r4=3, r5=11.
- Hold mid-stream:
  - Stimulus: issue 4 operations, with hold=1 for 3 cycles after the second.
  - Response: in_ready=0 during hold; no bank or memory writes during hold; final results identical to the no-hold run, shifted by 3 cycles.
- Function sweep, DATA_W=16:
  - A=0x8001, B=0x0004.
  - Add gives 0x8005 with carry 0.
  - B−A gives 0x8003 with borrow 1.
  - func 8 gives 0x0010; func 9 gives 0x0800; func 11 gives 0.
  - func 15 gives 0 with z_zero=1.
- Memory path:
  - Stimulus: issue or with result 0x00FF to addr 0xA5, followed by bubbles.
  - Response: mem_dbg_data at 0xA5 reads 0x00FF starting the cycle after edge N+3 and not before.
- Parameter variant:
  - Configuration: DATA_W=32, REG_AW=5, MEM_AW=10.
  - Stimulus: add 0xFFFFFFFF+1, then store to addr 0x3FF.
  - Response: z_out=0, z_carry=1, z_zero=1; memory location 0x3FF reads 0.

Source files
------------

// File: rtl/alu_pipe_fwd_if.sv
// Issue-side bus of alu_pipe_fwd: operation handshake, global hold and the
// stage-3 result/flag outputs.
interface alu_pipe_fwd_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              hold;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [MEM_AW-1:0] addr;
  logic [DATA_W-1:0] z_out;
  logic              z_valid;
  logic              z_zero;
  logic              z_carry;

  // Issue logic side
  modport master (
    output in_valid, hold, rs1, rs2, rd, func, addr,
    input  in_ready, z_out, z_valid, z_zero, z_carry
  );

  // Pipeline side
  modport slave (
    input  in_valid, hold, rs1, rs2, rd, func, addr,
    output in_ready, z_out, z_valid, z_zero, z_carry
  );
endinterface

// File: rtl/alu_pipe_fwd.sv
// alu_pipe_fwd: register-read / ALU / writeback / memory-write pipeline with
// full operand forwarding, valid/ready intake and a global freeze (hold).
module alu_pipe_fwd #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_pipe_fwd_if.slave     bus,
  input  logic [REG_AW-1:0] rf_dbg_addr,
  output logic [DATA_W-1:0] rf_dbg_data,
  input  logic [MEM_AW-1:0] mem_dbg_addr,
  output logic [DATA_W-1:0] mem_dbg_data
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int NREG = 2**REG_AW;
  localparam int NMEM = 2**MEM_AW;

  localparam logic [3:0] F_ADD  = 4'd1;
  localparam logic [3:0] F_SUB  = 4'd2;
  localparam logic [3:0] F_AND  = 4'd3;
  localparam logic [3:0] F_OR   = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_NOTB = 4'd6;
  localparam logic [3:0] F_NOTA = 4'd7;
  localparam logic [3:0] F_SHL  = 4'd8;
  localparam logic [3:0] F_SHR  = 4'd9;
  localparam logic [3:0] F_PASS = 4'd10;
  localparam logic [3:0] F_SLTU = 4'd11;

  // S1->S2: latched operands and control
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] rd;
    logic [3:0]        func;
    logic [MEM_AW-1:0] addr;
  } s1_t;

  // S2->S3: ALU result awaiting writeback
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              carry;
    logic [REG_AW-1:0] rd;
    logic [MEM_AW-1:0] addr;
  } s2_t;

  // S3->S4: architecturally visible result awaiting the memory write
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              carry;
    logic [MEM_AW-1:0] addr;
  } s3_t;

  s1_t  s1_q;
  s2_t  s2_q;
  s3_t  s3_q;
  logic [3:1] vld_pipe;

  logic [DATA_W-1:0] bank [NREG];
  logic [DATA_W-1:0] mem  [NMEM];

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign bus.in_ready = !bus.hold;

  // ALU on the S1 entry; its output is also the youngest forwarding source
  always_comb begin
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   dif;
    logic [SH_W-1:0]   sh;
    sum       = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    dif       = {1'b0, s1_q.a} - {1'b0, s1_q.b};
    sh        = s1_q.b[SH_W-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (s1_q.func)
      F_ADD:  begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
      F_SUB:  begin alu_res = dif[DATA_W-1:0]; alu_carry = dif[DATA_W]; end
      F_AND:  alu_res = s1_q.a & s1_q.b;
      F_OR:   alu_res = s1_q.a | s1_q.b;
      F_XOR:  alu_res = s1_q.a ^ s1_q.b;
      F_NOTB: alu_res = ~s1_q.b;
      F_NOTA: alu_res = ~s1_q.a;
      F_SHL:  alu_res = s1_q.a << sh;
      F_SHR:  alu_res = s1_q.a >> sh;
      F_PASS: alu_res = s1_q.a;
      F_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (s1_q.a < s1_q.b)};
      default: alu_res = '0;
    endcase
  end

  // Operand select: S1 ALU output beats S2 result beats the bank. S2 covers
  // the bank write landing on the same edge as this read.
  always_comb begin
    op_a = bank[bus.rs1];
    if (vld_pipe[2] && s2_q.rd == bus.rs1) op_a = s2_q.res;
    if (vld_pipe[1] && s1_q.rd == bus.rs1) op_a = alu_res;
    op_b = bank[bus.rs2];
    if (vld_pipe[2] && s2_q.rd == bus.rs2) op_b = s2_q.res;
    if (vld_pipe[1] && s1_q.rd == bus.rs2) op_b = alu_res;
  end

  // Stage registers and valid shift; hold freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else if (!bus.hold) begin
      vld_pipe <= {vld_pipe[2:1], bus.in_valid};
      if (bus.in_valid) begin
        s1_q.a    <= op_a;
        s1_q.b    <= op_b;
        s1_q.rd   <= bus.rd;
        s1_q.func <= bus.func;
        s1_q.addr <= bus.addr;
      end
      s2_q.res   <= alu_res;
      s2_q.carry <= alu_carry;
      s2_q.rd    <= s1_q.rd;
      s2_q.addr  <= s1_q.addr;
      s3_q.res   <= s2_q.res;
      s3_q.zero  <= (s2_q.res == '0);
      s3_q.carry <= s2_q.carry;
      s3_q.addr  <= s2_q.addr;
    end
  end

  // Register bank writeback from the valid S2 entry; cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else if (!bus.hold && vld_pipe[2]) begin
      bank[s2_q.rd] <= s2_q.res;
    end
  end

  // Memory write from the valid S3 entry; contents survive reset, and the
  // async clear of vld_pipe keeps reset edges write-free
  always_ff @(posedge clk) begin
    if (!bus.hold && vld_pipe[3]) mem[s3_q.addr] <= s3_q.res;
  end

  assign bus.z_out   = s3_q.res;
  assign bus.z_valid = vld_pipe[3];
  assign bus.z_zero  = s3_q.zero;
  assign bus.z_carry = s3_q.carry;

  assign rf_dbg_data  = bank[rf_dbg_addr];
  assign mem_dbg_data = mem[mem_dbg_addr];
endmodule

// File: tb/tb_alu_pipe_fwd.sv
// Scoreboard bench for alu_pipe_fwd: default 16-bit build plus a 32-bit
// variant sharing clock and reset.
module tb_alu_pipe_fwd;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_fwd_if #(.DATA_W(16), .REG_AW(4), .MEM_AW(8))  bus ();
  alu_pipe_fwd_if #(.DATA_W(32), .REG_AW(5), .MEM_AW(10)) bus32 ();

  logic [3:0]  rf_a;   logic [15:0] rf_d;
  logic [7:0]  m_a;    logic [15:0] m_d;
  logic [4:0]  rf32_a; logic [31:0] rf32_d;
  logic [9:0]  m32_a;  logic [31:0] m32_d;

  alu_pipe_fwd #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_dbg_addr(rf_a), .rf_dbg_data(rf_d),
    .mem_dbg_addr(m_a), .mem_dbg_data(m_d)
  );

  alu_pipe_fwd #(.DATA_W(32), .REG_AW(5), .MEM_AW(10)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32),
    .rf_dbg_addr(rf32_a), .rf_dbg_data(rf32_d),
    .mem_dbg_addr(m32_a), .mem_dbg_data(m32_d)
  );

  typedef struct {
    logic [31:0] z;
    logic        zr;
    logic        c;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [7:0] a,
                       input logic [15:0] ez, input logic ec);
    bus.in_valid = 1'b1; bus.func = f; bus.rd = d;
    bus.rs1 = s1; bus.rs2 = s2; bus.addr = a;
    q16.push_back('{z: {16'h0, ez}, zr: (ez == 16'h0), c: ec});
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [3:0] f, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [9:0] a,
                         input logic [31:0] ez, input logic ec);
    bus32.in_valid = 1'b1; bus32.func = f; bus32.rd = d;
    bus32.rs1 = s1; bus32.rs2 = s2; bus32.addr = a;
    q32.push_back('{z: ez, zr: (ez == 32'h0), c: ec});
    step();
    bus32.in_valid = 1'b0;
  endtask

  task automatic rf16(input logic [3:0] r, input logic [15:0] v);
    rf_a = r;
    #1 check($sformatf("rf16_r%0d", r), {16'h0, rf_d}, {16'h0, v});
  endtask

  task automatic mem16(input string name, input logic [7:0] a, input logic [15:0] v);
    m_a = a;
    #1 check(name, {16'h0, m_d}, {16'h0, v});
  endtask

  // Monitor: pop one expectation per result presented after an advancing edge
  initial begin
    forever begin
      logic adv;
      exp_t e;
      @(posedge clk);
      adv = rst_n && !bus.hold;
      @(negedge clk);
      if (adv && bus.z_valid) begin
        if (q16.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected16: got z=%0h want no result", bus.z_out);
        end else begin
          e = q16.pop_front();
          check("z16", {16'h0, bus.z_out}, e.z);
          check("zero16", {31'h0, bus.z_zero}, {31'h0, e.zr});
          check("carry16", {31'h0, bus.z_carry}, {31'h0, e.c});
        end
      end
    end
  end

  initial begin
    forever begin
      logic adv;
      exp_t e;
      @(posedge clk);
      adv = rst_n && !bus32.hold;
      @(negedge clk);
      if (adv && bus32.z_valid) begin
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected32: got z=%0h want no result", bus32.z_out);
        end else begin
          e = q32.pop_front();
          check("z32", bus32.z_out, e.z);
          check("zero32", {31'h0, bus32.z_zero}, {31'h0, e.zr});
          check("carry32", {31'h0, bus32.z_carry}, {31'h0, e.c});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid = 0; bus.hold = 0; bus.rs1 = 0; bus.rs2 = 0; bus.rd = 0; bus.func = 0; bus.addr = 0;
    bus32.in_valid = 0; bus32.hold = 0; bus32.rs1 = 0; bus32.rs2 = 0; bus32.rd = 0;
    bus32.func = 0; bus32.addr = 0;
    rf_a = 0; m_a = 0; rf32_a = 0; m32_a = 0;

    // reset state
    #1;
    check("rst_zvalid", {31'h0, bus.z_valid}, 32'h0);
    check("rst_zout", {16'h0, bus.z_out}, 32'h0);
    check("rst_ready", {31'h0, bus.in_ready}, 32'h1);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // constant setup, dependent back-to-back: r15=FFFF r14=1 r13=2 r2=3 r12=4 r1=5
    issue(4'd7,  4'd15, 4'd0,  4'd0,  8'h00, 16'hFFFF, 1'b0);
    issue(4'd11, 4'd14, 4'd0,  4'd15, 8'h00, 16'h0001, 1'b0);
    issue(4'd1,  4'd13, 4'd14, 4'd14, 8'h00, 16'h0002, 1'b0);
    issue(4'd1,  4'd2,  4'd13, 4'd14, 8'h00, 16'h0003, 1'b0);
    issue(4'd1,  4'd12, 4'd13, 4'd13, 8'h00, 16'h0004, 1'b0);
    issue(4'd1,  4'd1,  4'd12, 4'd14, 8'h00, 16'h0005, 1'b0);
    issue(4'd8,  4'd10, 4'd14, 4'd15, 8'h00, 16'h8000, 1'b0);
    issue(4'd1,  4'd11, 4'd10, 4'd14, 8'h00, 16'h8001, 1'b0);
    issue(4'd1,  4'd8,  4'd12, 4'd12, 8'h00, 16'h0008, 1'b0);
    issue(4'd9,  4'd9,  4'd15, 4'd8,  8'h00, 16'h00FF, 1'b0);
    // RAW chain
    issue(4'd1,  4'd3,  4'd1,  4'd2,  8'h00, 16'h0008, 1'b0);
    issue(4'd2,  4'd4,  4'd3,  4'd1,  8'h00, 16'h0003, 1'b0);
    issue(4'd5,  4'd5,  4'd4,  4'd3,  8'h00, 16'h000B, 1'b0);
    // function sweep, A=r11=8001 B=r12=0004
    issue(4'd1,  4'd6,  4'd11, 4'd12, 8'h10, 16'h8005, 1'b0);
    issue(4'd2,  4'd6,  4'd12, 4'd11, 8'h10, 16'h8003, 1'b1);
    issue(4'd2,  4'd6,  4'd11, 4'd12, 8'h10, 16'h7FFD, 1'b0);
    issue(4'd1,  4'd6,  4'd15, 4'd14, 8'h10, 16'h0000, 1'b1);
    issue(4'd3,  4'd6,  4'd11, 4'd12, 8'h10, 16'h0000, 1'b0);
    issue(4'd4,  4'd6,  4'd11, 4'd12, 8'h10, 16'h8005, 1'b0);
    issue(4'd5,  4'd6,  4'd11, 4'd12, 8'h10, 16'h8005, 1'b0);
    issue(4'd6,  4'd6,  4'd11, 4'd12, 8'h10, 16'hFFFB, 1'b0);
    issue(4'd7,  4'd6,  4'd11, 4'd12, 8'h10, 16'h7FFE, 1'b0);
    issue(4'd8,  4'd6,  4'd11, 4'd12, 8'h10, 16'h0010, 1'b0);
    issue(4'd9,  4'd6,  4'd11, 4'd12, 8'h10, 16'h0800, 1'b0);
    issue(4'd10, 4'd6,  4'd11, 4'd12, 8'h10, 16'h8001, 1'b0);
    issue(4'd11, 4'd6,  4'd11, 4'd12, 8'h10, 16'h0000, 1'b0);
    issue(4'd15, 4'd6,  4'd11, 4'd12, 8'hA5, 16'h0000, 1'b0);
    issue(4'd0,  4'd6,  4'd11, 4'd12, 8'h10, 16'h0000, 1'b0);
    repeat (4) step();
    rf16(4'd1, 16'h0005); rf16(4'd2, 16'h0003);
    rf16(4'd3, 16'h0008); rf16(4'd4, 16'h0003); rf16(4'd5, 16'h000B);

    // memory path: or r7 = r9|r0 = 00FF -> A5; visible only after edge N+3
    issue(4'd4, 4'd7, 4'd9, 4'd0, 8'hA5, 16'h00FF, 1'b0);
    mem16("mem_at_n", 8'hA5, 16'h0000);
    step(); mem16("mem_at_n1", 8'hA5, 16'h0000);
    step(); mem16("mem_at_n2", 8'hA5, 16'h0000);
    step(); mem16("mem_at_n3", 8'hA5, 16'h00FF);
    repeat (2) step();

    // hold for 3 edges after the second of four operations
    issue(4'd1, 4'd6, 4'd1, 4'd2,  8'h10, 16'h0008, 1'b0);
    issue(4'd2, 4'd7, 4'd6, 4'd14, 8'h11, 16'h0007, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_ready", {31'h0, bus.in_ready}, 32'h0);
      check("hold_zvalid", {31'h0, bus.z_valid}, 32'h0);
      rf16(4'd6, 16'h0000);
      mem16("hold_mem10", 8'h10, 16'h0000);
      step();
    end
    rf16(4'd6, 16'h0000);
    bus.hold = 1'b0;
    issue(4'd5, 4'd8, 4'd7, 4'd6, 8'h12, 16'h000F, 1'b0);
    issue(4'd1, 4'd9, 4'd8, 4'd7, 8'h13, 16'h0016, 1'b0);
    repeat (4) step();
    rf16(4'd6, 16'h0008); rf16(4'd7, 16'h0007); rf16(4'd8, 16'h000F); rf16(4'd9, 16'h0016);
    mem16("hmem10", 8'h10, 16'h0008); mem16("hmem11", 8'h11, 16'h0007);
    mem16("hmem12", 8'h12, 16'h000F); mem16("hmem13", 8'h13, 16'h0016);

    // reset mid-stream with three operations in flight, all aimed at A5
    issue(4'd7,  4'd1, 4'd0, 4'd0, 8'hA5, 16'hFFFF, 1'b0);
    issue(4'd1,  4'd2, 4'd1, 4'd1, 8'hA5, 16'hFFFE, 1'b1);
    issue(4'd10, 4'd3, 4'd2, 4'd0, 8'hA5, 16'hFFFE, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q16.delete();
    #1;
    check("mrst_zvalid", {31'h0, bus.z_valid}, 32'h0);
    check("mrst_zout", {16'h0, bus.z_out}, 32'h0);
    check("mrst_zzero", {31'h0, bus.z_zero}, 32'h0);
    check("mrst_zcarry", {31'h0, bus.z_carry}, 32'h0);
    for (int r = 0; r < 16; r++) rf16(r[3:0], 16'h0000);
    mem16("mrst_memA5", 8'hA5, 16'h00FF);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    issue(4'd7, 4'd1, 4'd0, 4'd0, 8'h20, 16'hFFFF, 1'b0);
    repeat (4) step();
    mem16("post_memA5", 8'hA5, 16'h00FF);
    mem16("post_mem20", 8'h20, 16'hFFFF);
    rf16(4'd1, 16'hFFFF);

    // 32-bit variant: FFFFFFFF + 1 -> 0 with carry, stored to 3FF
    issue32(4'd7,  5'd1, 5'd0, 5'd0, 10'h3FF, 32'hFFFFFFFF, 1'b0);
    issue32(4'd11, 5'd2, 5'd0, 5'd1, 10'h000, 32'h00000001, 1'b0);
    issue32(4'd1,  5'd3, 5'd1, 5'd2, 10'h3FF, 32'h00000000, 1'b1);
    repeat (4) step();
    m32_a = 10'h3FF;
    #1 check("mem32_3ff", m32_d, 32'h0);
    rf32_a = 5'd3;
    #1 check("rf32_r3", rf32_d, 32'h0);

    step();
    check("q16_drained", q16.size(), 32'h0);
    check("q32_drained", q32.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
